tcm_core: RTL and testbench
===========================

TCM_CORE -- requirements
Module: tcm_core

Interface
REQ-001 SHALL have ports: CLK  in  1  rising-edge clock.
REQ-002 SHALL have ports: RESET  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: START  in  1  run request, sampled only in IDLE or HALTED.
REQ-004 SHALL have ports: Q  in  8  instruction word from instruction memory, combinational from ADDR.
REQ-005 SHALL have ports: ADDR  out  8  instruction fetch address (equals PC).
REQ-006 SHALL have ports: A_OUT  out  8  counter A; B_OUT  out  8  counter B.
REQ-007 SHALL have ports: BUSY  out  1  high in FETCH or EXEC; HALTED  out  1  high in HALTED state.
REQ-008 SHALL have ports: OVF  out  1  sticky flag, set when any INC wraps 255->0.
REQ-009 SHALL have no parameters; PC, A, B are fixed 8-bit.

Function
REQ-010 SHALL implement states IDLE, FETCH, EXEC, HALTED with one transition per CLK edge.
REQ-011 IDLE/HALTED with START=1 -> FETCH; also PC<=0, A<=0, B<=0, OVF<=0 on that edge.
REQ-012 IDLE/HALTED with START=0 -> stay; all registers hold.
REQ-013 FETCH -> EXEC; IR<=Q on that edge; PC, A, B unchanged.
REQ-014 EXEC executes IR (upper nibble = opcode, lower nibble = operand); -> HALTED if HALT, else -> FETCH.
REQ-015 Opcodes: 0010 CLR A (A<=0); 0011 CLR B (B<=0).
REQ-016 Opcodes: 0100 INC A; 0101 INC B; increment mod 256, set OVF on 255->0.
REQ-017 Opcodes: 0110 DEC A; 0111 DEC B; saturate at 0 (0 stays 0, no flag).
REQ-018 Opcodes: 1000 CPY A B (A<=B); 1001 CPY B A (B<=A).
REQ-019 Opcodes: 1010 JMPZ A; 1011 JMPZ B; jump if selected counter == 0.
REQ-020 Opcodes: 1100 JMP (unconditional); 1101 JMPE (jump if A == B).
REQ-021 Opcode 1110 HALT: PC, A, B hold.
REQ-022 Opcodes 0000, 0001, 1111: NOP.
REQ-023 Jump offset = lower nibble, 4-bit two's complement (-8..+7), sign-extended to 8 bits.
REQ-024 Taken jump: PC<=PC+offset mod 256; not-taken or non-jump: PC<=PC+1 mod 256 (255 wraps to 0).
REQ-025 Offset 0 on a taken jump is a self-loop; it is not treated as HALT.
REQ-026 Jump conditions and CPY sources SHALL use pre-EXEC values of A and B.
REQ-027 START while BUSY SHALL be ignored with no effect on state or registers.
REQ-028 Each non-HALT instruction takes exactly 2 cycles (FETCH + EXEC).
REQ-029 ADDR SHALL equal PC combinationally in all states.
REQ-030 Q is only sampled in FETCH; Q changes in other states SHALL have no effect.

Reset
REQ-031 RESET=0 SHALL immediately force IDLE, PC=0, IR=0, A=0, B=0, OVF=0 (ADDR=0, BUSY=0, HALTED=0), independent of CLK.
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction; no partial register update persists.
REQ-033 After RESET deasserts, the block SHALL remain in IDLE until START=1 is sampled.

Verification
REQ-034 Program memory: 0-4 INC A (0x40); 5-6 INC B (0x50); 7 JMPZ B +4 (0xB4); 8 DEC B (0x70); 9 DEC A (0x60); 10 JMP -3 (0xCD); 11 CPY B A (0x91); 12 CLR B (0x30); 13 HALT (0xE0).
    Stimulus: START pulse. Required: 19 instructions executed, HALTED at edge 39 after the START edge, then A=3, B=0, ADDR=13, OVF=0.
REQ-035 Stimulus: DEC A with A=0. Required: A=0, no flag.
    Stimulus: INC A 256 times from 0. Required: A=0, OVF=1, OVF held through later instructions.
REQ-036 Stimulus: PC=254 executing JMP +7 (0xC7). Required: PC=5.
    Stimulus: PC=3 executing JMP -8 (0xC8). Required: PC=251.
    Stimulus: NOP run at PC=255. Required: PC wraps to 0.
REQ-037 Stimulus: JMPE with A=B=7. Required: jump taken.
    Stimulus: JMPE with A=7, B=6. Required: PC+1.
    Stimulus: JMPZ B with B=0. Required: jump taken.
    Stimulus: CPY A B. Required: A takes the old B value.
REQ-038 Stimulus: RESET low during EXEC of INC B with B=9. Required: B=0 and IDLE immediately.
    Stimulus: START held high while BUSY. Required: no restart.
    Stimulus: START in HALTED. Required: PC/A/B/OVF cleared, FETCH next cycle.

Source files
------------

// File: rtl/tcm_core_if.sv
// ---------------------------------------------------------------------------
// tcm_core_if -- run control, instruction fetch and status bundle of tcm_core
//
//   START   run request (driven by master)
//   Q       instruction byte, combinational from ADDR (driven by master)
//   ADDR    fetch address, equals PC (driven by core)
//   A_OUT   counter A (driven by core)
//   B_OUT   counter B (driven by core)
//   BUSY    high while fetching or executing (driven by core)
//   HALTED  high in the halted state (driven by core)
//   OVF     sticky increment-wrap flag (driven by core)
// ---------------------------------------------------------------------------
interface tcm_core_if;
    logic       START;
    logic [7:0] Q;
    logic [7:0] ADDR;
    logic [7:0] A_OUT;
    logic [7:0] B_OUT;
    logic       BUSY;
    logic       HALTED;
    logic       OVF;

    modport master (
        output START, Q,
        input  ADDR, A_OUT, B_OUT, BUSY, HALTED, OVF
    );

    modport slave (
        input  START, Q,
        output ADDR, A_OUT, B_OUT, BUSY, HALTED, OVF
    );
endinterface

// File: rtl/tcm_core.sv
// ---------------------------------------------------------------------------
// tcm_core -- tiny two-counter machine
//
// Fetches 8-bit instructions (opcode in the upper nibble, operand in the
// lower nibble) from an external combinational memory and executes them on
// two 8-bit counters A and B. Every instruction takes one FETCH and one EXEC
// cycle; HALT parks the core until START is seen again.
//
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    tcm_core_if.slave: START/Q in, ADDR/A_OUT/B_OUT/BUSY/HALTED/OVF out
// ---------------------------------------------------------------------------
module tcm_core (
    input  logic        CLK,
    input  logic        RESET,
    tcm_core_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pc,    w_pc_nxt;
    logic [7:0] r_ir,    w_ir_nxt;
    logic [7:0] r_a,     w_a_nxt;
    logic [7:0] r_b,     w_b_nxt;
    logic       r_ovf,   w_ovf_nxt;

    logic [3:0] w_opcode;
    logic [7:0] w_offset;
    logic       w_taken;

    assign w_opcode = r_ir[7:4];
    // Operand nibble is a signed jump offset, sign-extended to PC width.
    assign w_offset = {{4{r_ir[3]}}, r_ir[3:0]};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_ovf_nxt   = r_ovf;
        w_taken     = 1'b0;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (bus.START) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end

            S_FETCH: begin
                w_ir_nxt    = bus.Q;
                w_state_nxt = S_EXEC;
            end

            S_EXEC: begin
                w_state_nxt = S_FETCH;
                // Conditions and copy sources read r_a/r_b, i.e. the values
                // before this instruction, so A<->B copies never chain.
                case (w_opcode)
                    4'b0010: w_a_nxt = '0;
                    4'b0011: w_b_nxt = '0;
                    4'b0100: begin
                        w_a_nxt = r_a + 8'd1;
                        if (r_a == 8'hFF) w_ovf_nxt = 1'b1;
                    end
                    4'b0101: begin
                        w_b_nxt = r_b + 8'd1;
                        if (r_b == 8'hFF) w_ovf_nxt = 1'b1;
                    end
                    4'b0110: if (r_a != 8'd0) w_a_nxt = r_a - 8'd1;
                    4'b0111: if (r_b != 8'd0) w_b_nxt = r_b - 8'd1;
                    4'b1000: w_a_nxt = r_b;
                    4'b1001: w_b_nxt = r_a;
                    4'b1010: w_taken = (r_a == 8'd0);
                    4'b1011: w_taken = (r_b == 8'd0);
                    4'b1100: w_taken = 1'b1;
                    4'b1101: w_taken = (r_a == r_b);
                    4'b1110: w_state_nxt = S_HALTED;
                    default: ;
                endcase

                if (w_opcode != 4'b1110) begin
                    w_pc_nxt = w_taken ? (r_pc + w_offset) : (r_pc + 8'd1);
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.ADDR   = r_pc;
    assign bus.A_OUT  = r_a;
    assign bus.B_OUT  = r_b;
    assign bus.OVF    = r_ovf;
    assign bus.BUSY   = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign bus.HALTED = (r_state == S_HALTED);

endmodule

// File: tb/tb_tcm_core.sv
// ---------------------------------------------------------------------------
// tb_tcm_core -- self-checking bench for tcm_core
//
// Holds the instruction memory and an instruction-level reference model of
// the counter machine; directed programs plus random programs.
// ---------------------------------------------------------------------------
module tb_tcm_core;

    logic CLK = 1'b0;
    logic RESET;

    logic [7:0] mem [256];

    int n_total = 0;
    int n_bad   = 0;

    // Reference machine state (instruction granularity)
    int m_pc, m_a, m_b, m_ovf, m_halted;
    int n_edges;

    tcm_core_if bus ();

    tcm_core dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    assign bus.Q = mem[bus.ADDR];

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    function automatic int jump_target(input int pc, input int nib);
        int off;
        off = (nib >= 8) ? nib - 16 : nib;
        return (pc + off + 256) % 256;
    endfunction

    // One instruction at the architectural level.
    task automatic model_step();
        int ir, op, nib, pa, pb, take;
        ir   = int'(mem[m_pc]);
        op   = ir / 16;
        nib  = ir % 16;
        pa   = m_a;
        pb   = m_b;
        take = 0;
        case (op)
            2:  m_a = 0;
            3:  m_b = 0;
            4:  begin m_a = m_a + 1; if (m_a == 256) begin m_a = 0; m_ovf = 1; end end
            5:  begin m_b = m_b + 1; if (m_b == 256) begin m_b = 0; m_ovf = 1; end end
            6:  if (m_a > 0) m_a = m_a - 1;
            7:  if (m_b > 0) m_b = m_b - 1;
            8:  m_a = pb;
            9:  m_b = pa;
            10: take = (pa == 0);
            11: take = (pb == 0);
            12: take = 1;
            13: take = (pa == pb);
            default: ;
        endcase
        if (op == 14)     m_halted = 1;
        else if (take)    m_pc = jump_target(m_pc, nib);
        else              m_pc = (m_pc + 1) % 256;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_addr",   bus.ADDR,   0);
        chk("rst_a",      bus.A_OUT,  0);
        chk("rst_b",      bus.B_OUT,  0);
        chk("rst_busy",   bus.BUSY,   0);
        chk("rst_halted", bus.HALTED, 0);
        chk("rst_ovf",    bus.OVF,    0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("idle_busy", bus.BUSY, 0);
        m_pc = 0; m_a = 0; m_b = 0; m_ovf = 0; m_halted = 0;
    endtask

    // Called #1 after an edge with the core in IDLE or HALTED.
    task automatic start_pulse();
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        m_pc = 0; m_a = 0; m_b = 0; m_ovf = 0; m_halted = 0;
        n_edges = 1;
        chk("start_busy", bus.BUSY,   1);
        chk("start_hlt",  bus.HALTED, 0);
        chk("start_addr", bus.ADDR,   0);
        chk("start_a",    bus.A_OUT,  0);
        chk("start_b",    bus.B_OUT,  0);
        chk("start_ovf",  bus.OVF,    0);
    endtask

    // Called #1 after an edge with the core in FETCH.
    task automatic run_instr();
        int pc0;
        pc0 = m_pc;
        @(posedge CLK);
        #1;
        chk("fetch_busy", bus.BUSY, 1);
        chk("fetch_addr", bus.ADDR, pc0);
        model_step();
        @(posedge CLK);
        #1;
        n_edges += 2;
        chk("exec_addr",   bus.ADDR,   m_pc);
        chk("exec_a",      bus.A_OUT,  m_a);
        chk("exec_b",      bus.B_OUT,  m_b);
        chk("exec_ovf",    bus.OVF,    m_ovf);
        chk("exec_halted", bus.HALTED, m_halted);
        chk("exec_busy",   bus.BUSY,   m_halted ? 0 : 1);
    endtask

    initial begin
        int n;
        RESET     = 1'b0;
        bus.START = 1'b0;
        clear_mem();
        #3;
        chk("por_addr", bus.ADDR, 0);
        chk("por_busy", bus.BUSY, 0);
        do_reset();

        // Counting program
        clear_mem();
        for (int i = 0; i <= 4; i++) mem[i] = 8'h40;
        mem[5] = 8'h50; mem[6] = 8'h50; mem[7] = 8'hB4; mem[8]  = 8'h70;
        mem[9] = 8'h60; mem[10] = 8'hCD; mem[11] = 8'h91; mem[12] = 8'h30;
        mem[13] = 8'hE0;
        start_pulse();
        n = 0;
        while (!m_halted && n < 60) begin
            run_instr();
            n++;
        end
        chk("prog_count",  n,          19);
        chk("prog_edges",  n_edges,    39);
        chk("prog_halted", bus.HALTED, 1);
        chk("prog_a",      bus.A_OUT,  3);
        chk("prog_b",      bus.B_OUT,  0);
        chk("prog_addr",   bus.ADDR,   13);
        chk("prog_ovf",    bus.OVF,    0);
        repeat (3) @(posedge CLK);
        #1;
        chk("halt_hold", bus.ADDR, 13);
        // Restart from HALTED clears everything and fetches from 0.
        start_pulse();
        run_instr();
        do_reset();

        // DEC A at zero, then INC A wrapping
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h40; mem[2] = 8'hCF;
        start_pulse();
        run_instr();
        chk("dec0_a",   bus.A_OUT, 0);
        chk("dec0_ovf", bus.OVF,   0);
        for (int i = 0; i < 512; i++) run_instr();
        chk("wrap_a",   bus.A_OUT, 0);
        chk("wrap_ovf", bus.OVF,   1);
        repeat (6) run_instr();
        chk("ovf_held", bus.OVF, 1);
        do_reset();

        // Jump arithmetic and PC wrap
        clear_mem();
        mem[3] = 8'hC8; mem[251] = 8'hC3; mem[254] = 8'hC7;
        mem[5] = 8'hC8; mem[253] = 8'hC2; mem[255] = 8'h00;
        start_pulse();
        repeat (4) run_instr();
        chk("jmp_m8", bus.ADDR, 251);
        run_instr();
        chk("jmp_to254", bus.ADDR, 254);
        run_instr();
        chk("jmp_p7", bus.ADDR, 5);
        repeat (2) run_instr();
        chk("jmp_to255", bus.ADDR, 255);
        run_instr();
        chk("nop_wrap", bus.ADDR, 0);
        do_reset();

        // JMPE / JMPZ / CPY with pre-execution operands
        clear_mem();
        for (int i = 0; i <= 6; i++)  mem[i] = 8'h40;
        for (int i = 7; i <= 13; i++) mem[i] = 8'h50;
        mem[14] = 8'hD3; mem[17] = 8'h71; mem[18] = 8'hD5; mem[19] = 8'h33;
        mem[20] = 8'hB4; mem[24] = 8'h50; mem[25] = 8'h80; mem[26] = 8'hE0;
        start_pulse();
        repeat (15) run_instr();
        chk("jmpe_taken", bus.ADDR, 17);
        repeat (2) run_instr();
        chk("jmpe_not", bus.ADDR, 19);
        repeat (2) run_instr();
        chk("jmpz_b", bus.ADDR, 24);
        repeat (2) run_instr();
        chk("cpy_ab", bus.A_OUT, 1);
        run_instr();
        chk("cpy_halt", bus.HALTED, 1);
        do_reset();

        // START held while busy
        clear_mem();
        for (int i = 0; i <= 3; i++) mem[i] = 8'h40;
        mem[4] = 8'hE0;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        m_pc = 0; m_a = 0; m_b = 0; m_ovf = 0; m_halted = 0;
        repeat (4) run_instr();
        bus.START = 1'b0;
        chk("hold_start_a",    bus.A_OUT, 4);
        chk("hold_start_addr", bus.ADDR,  4);
        run_instr();
        do_reset();

        // Reset in the middle of INC B execution
        clear_mem();
        for (int i = 0; i <= 9; i++) mem[i] = 8'h50;
        start_pulse();
        repeat (9) run_instr();
        chk("pre_rst_b", bus.B_OUT, 9);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        chk("mid_rst_b",    bus.B_OUT, 0);
        chk("mid_rst_busy", bus.BUSY,  0);
        chk("mid_rst_addr", bus.ADDR,  0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("post_rst_idle", bus.BUSY, 0);
        chk("post_rst_b",    bus.B_OUT, 0);
        chk("post_rst_addr", bus.ADDR,  0);

        // Random programs
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom_range(0, 255));
                if (mem[i][7:4] == 4'hE && $urandom_range(0, 3) != 0) mem[i] = 8'h45;
            end
            do_reset();
            start_pulse();
            for (int k = 0; k < 200; k++) begin
                if (m_halted) start_pulse();
                else          run_instr();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
